// File: rtl/mem_access.sv
// mem_access: memory-access stage of the 5-stage RV32 core.
// Runs one outstanding req/ack transaction to the data memory, aligns store
// lanes, extracts/extends load data and registers the writeback bundle.
// Optional feature macro: MISALIGN_EXC_EN (misaligned half/word ops raise
// misalign_o instead of being forced to an aligned access).
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_i,
    input  logic              wreg_i,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [DATA_W-1:0] dm_wdata_o,
    output logic [3:0]        dm_be_o,
    input  logic              dm_ack_i,
    input  logic [DATA_W-1:0] dm_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_wreg_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
`ifdef MISALIGN_EXC_EN
    output logic              misalign_o,
`endif
    output logic              stallreq_o
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state, state_next;
    logic        is_mem;
    logic        accept;
    logic        done;
    logic        op_load;
    logic [1:0]  op_size;
    logic        op_uns;
    logic [1:0]  op_off;
    logic [4:0]  op_rd;
    logic        op_wreg;
    logic        flush_pend;
    logic [1:0]  cur_off;

    // Byte offset inside the word; half/word offsets are forced aligned.
    function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   lane_off = a;
            2'b01:   lane_off = {a[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across all lanes so any be pattern picks it up.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   load_ext = {{24{sh[7] & ~uns}}, sh[7:0]};
            2'b01:   load_ext = {{16{sh[15] & ~uns}}, sh[15:0]};
            default: load_ext = rdata;
        endcase
    endfunction

`ifdef MISALIGN_EXC_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    logic misaligned;
    assign misaligned = is_misaligned(mem_size_i, addr_i[1:0]);
    assign accept     = (state == IDLE) & is_mem & ~flush_i & ~misaligned;
    // A rejected misaligned op never holds the pipeline.
    assign stallreq_o = is_mem & ~done & ~((state == IDLE) & misaligned);
`else
    assign accept     = (state == IDLE) & is_mem & ~flush_i;
    assign stallreq_o = is_mem & ~done;
`endif

    assign is_mem  = valid_i & (mem_rd_i | mem_wr_i);
    assign done    = (state == BUSY) & dm_ack_i & dm_req_o;
    assign cur_off = lane_off(mem_size_i, addr_i[1:0]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE accepts a memory op, BUSY waits for the ack.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (done) begin
                    state_next = IDLE;
                end else begin
                    state_next = BUSY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus request, latched op context and registered writeback bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_req_o   <= 1'b0;
            dm_we_o    <= 1'b0;
            dm_addr_o  <= {ADDR_W{1'b0}};
            dm_wdata_o <= {DATA_W{1'b0}};
            dm_be_o    <= 4'b0000;
            wb_valid_o <= 1'b0;
            wb_wreg_o  <= 1'b0;
            wb_rd_o    <= 5'd0;
            wb_data_o  <= {DATA_W{1'b0}};
            op_load    <= 1'b0;
            op_size    <= 2'b00;
            op_uns     <= 1'b0;
            op_off     <= 2'b00;
            op_rd      <= 5'd0;
            op_wreg    <= 1'b0;
            flush_pend <= 1'b0;
`ifdef MISALIGN_EXC_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
`ifdef MISALIGN_EXC_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        dm_req_o   <= 1'b1;
                        dm_we_o    <= mem_wr_i;
                        dm_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                        dm_wdata_o <= lane_data(mem_size_i, wdata_i);
                        dm_be_o    <= lane_be(mem_size_i, cur_off);
                        op_load    <= mem_rd_i;
                        op_size    <= mem_size_i;
                        op_uns     <= mem_unsigned_i;
                        op_off     <= cur_off;
                        op_rd      <= rd_i;
                        op_wreg    <= wreg_i;
                        flush_pend <= 1'b0;
                    end else if (valid_i & ~is_mem) begin
                        wb_valid_o <= ~flush_i;
                        wb_wreg_o  <= wreg_i;
                        wb_rd_o    <= rd_i;
                        wb_data_o  <= addr_i;
                    end else begin
`ifdef MISALIGN_EXC_EN
                        misalign_o <= is_mem & ~flush_i & misaligned;
`endif
                        flush_pend <= 1'b0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        dm_req_o   <= 1'b0;
                        dm_we_o    <= 1'b0;
                        wb_valid_o <= op_load & ~flush_pend & ~flush_i;
                        wb_wreg_o  <= op_load & op_wreg;
                        wb_rd_o    <= op_rd;
                        flush_pend <= 1'b0;
                        if (op_load) begin
                            wb_data_o <= load_ext(op_size, op_uns, op_off, dm_rdata_i);
                        end else begin
                            wb_data_o <= wb_data_o;
                        end
                    end else begin
                        flush_pend <= flush_pend | flush_i;
                    end
                end
                default: begin
                    dm_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (default build).
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, flush, mem_rd, mem_wr, mem_uns, wreg, dm_ack;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata, dm_rdata;
    logic [4:0]  rd;
    logic        dm_req, dm_we, wb_valid, wb_wreg, stallreq;
    logic [31:0] dm_addr, dm_wdata, wb_data;
    logic [3:0]  dm_be;
    logic [4:0]  wb_rd;
`ifdef MISALIGN_EXC_EN
    logic        misalign;
`endif
    int n_cmp = 0;
    int n_err = 0;

    mem_access dut (
        .clk(clk), .rst(rst), .valid_i(valid), .flush_i(flush),
        .mem_rd_i(mem_rd), .mem_wr_i(mem_wr), .mem_size_i(mem_size),
        .mem_unsigned_i(mem_uns), .addr_i(addr), .wdata_i(wdata),
        .rd_i(rd), .wreg_i(wreg), .dm_req_o(dm_req), .dm_we_o(dm_we),
        .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_be_o(dm_be),
        .dm_ack_i(dm_ack), .dm_rdata_i(dm_rdata), .wb_valid_o(wb_valid),
        .wb_wreg_o(wb_wreg), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
`ifdef MISALIGN_EXC_EN
        .misalign_o(misalign),
`endif
        .stallreq_o(stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        valid = 1'b0; flush = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_uns = 1'b0;
        wreg = 1'b0; dm_ack = 1'b0; mem_size = 2'b10; addr = 32'h0;
        wdata = 32'h0; dm_rdata = 32'h0; rd = 5'd0;
    endtask

    // Memory op presented at cycle 0, ack in cycle d (d >= 1), writeback checked at d+1.
    task automatic mem_op(input string tag, input logic is_wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] dst, input int d, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic exp_wbv,
                          input logic [31:0] exp_wbd);
        @(negedge clk);
        valid = 1'b1; mem_rd = ~is_wr; mem_wr = is_wr; mem_size = size; mem_uns = uns;
        addr = a; wdata = wd; rd = dst; wreg = ~is_wr; dm_ack = 1'b0;
        #1 chk({tag, "_stall0"}, {31'd0, stallreq}, 32'd1);
        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            chk({tag, "_req"}, {31'd0, dm_req}, 32'd1);
            if (i == 1) begin
                chk({tag, "_addr"}, dm_addr, exp_addr);
                chk({tag, "_be"}, {28'd0, dm_be}, {28'd0, exp_be});
                chk({tag, "_we"}, {31'd0, dm_we}, {31'd0, is_wr});
                if (is_wr) chk({tag, "_wdata"}, dm_wdata, exp_wd);
            end
            if (i == d) begin
                dm_ack = 1'b1; dm_rdata = rdata;
                #1 chk({tag, "_stall_ack"}, {31'd0, stallreq}, 32'd0);
            end else begin
                #1 chk({tag, "_stall_hold"}, {31'd0, stallreq}, 32'd1);
            end
        end
        @(negedge clk);
        idle_inputs();
        chk({tag, "_wbv"}, {31'd0, wb_valid}, {31'd0, exp_wbv});
        chk({tag, "_req_drop"}, {31'd0, dm_req}, 32'd0);
        if (exp_wbv) begin
            chk({tag, "_wbdata"}, wb_data, exp_wbd);
            chk({tag, "_wbrd"}, {27'd0, wb_rd}, {27'd0, dst});
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_be", {28'd0, dm_be}, 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_stall", {31'd0, stallreq}, 32'd0);
        rst = 1'b0;

        // Word store / load
        mem_op("sw", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0, 3, 32'h0,
               32'h100, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
        mem_op("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF,
               32'h100, 4'b1111, 32'h0, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        chk("lw_pulse", {31'd0, wb_valid}, 32'd0);

        // Sub-word stores
        mem_op("sb", 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 5'd0, 1, 32'h0,
               32'h100, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0);
        mem_op("sh", 1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 5'd0, 2, 32'h0,
               32'h100, 4'b1100, 32'h12341234, 1'b0, 32'h0);

        // Load extension from 0x80FF7F01
        mem_op("lb", 1'b0, 2'b00, 1'b0, 32'h202, 32'h0, 5'd6, 1, 32'h80FF7F01,
               32'h200, 4'b0100, 32'h0, 1'b1, 32'hFFFFFFFF);
        mem_op("lbu", 1'b0, 2'b00, 1'b1, 32'h202, 32'h0, 5'd6, 1, 32'h80FF7F01,
               32'h200, 4'b0100, 32'h0, 1'b1, 32'h000000FF);
        mem_op("lh", 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 5'd6, 1, 32'h80FF7F01,
               32'h200, 4'b1100, 32'h0, 1'b1, 32'hFFFF80FF);
        mem_op("lhu", 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 5'd6, 2, 32'h80FF7F01,
               32'h200, 4'b0011, 32'h0, 1'b1, 32'h00007F01);

        // Back-to-back: ALU, immediate-ack load, ALU
        @(negedge clk);
        valid = 1'b1; addr = 32'h1234; rd = 5'd3; wreg = 1'b1;
        @(negedge clk);
        chk("b2b_wbv1", {31'd0, wb_valid}, 32'd1);
        chk("b2b_data1", wb_data, 32'h1234);
        chk("b2b_rd1", {27'd0, wb_rd}, 32'd3);
        mem_rd = 1'b1; mem_size = 2'b10; addr = 32'h200; rd = 5'd7;
        #1 chk("b2b_stall", {31'd0, stallreq}, 32'd1);
        @(negedge clk);
        chk("b2b_wbv2", {31'd0, wb_valid}, 32'd0);
        chk("b2b_req", {31'd0, dm_req}, 32'd1);
        dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("b2b_wbv3", {31'd0, wb_valid}, 32'd1);
        chk("b2b_data3", wb_data, 32'hCAFEF00D);
        chk("b2b_rd3", {27'd0, wb_rd}, 32'd7);
        dm_ack = 1'b0; mem_rd = 1'b0; addr = 32'h55; rd = 5'd9;
        @(negedge clk);
        chk("b2b_wbv4", {31'd0, wb_valid}, 32'd1);
        chk("b2b_data4", wb_data, 32'h55);
        chk("b2b_rd4", {27'd0, wb_rd}, 32'd9);
        idle_inputs();
        @(negedge clk);
        chk("b2b_wbv5", {31'd0, wb_valid}, 32'd0);

        // Flush in IDLE: ALU op and memory op both squashed
        flush = 1'b1; valid = 1'b1; addr = 32'h77; rd = 5'd4; wreg = 1'b1;
        @(negedge clk);
        chk("flush_alu_wbv", {31'd0, wb_valid}, 32'd0);
        mem_rd = 1'b1; addr = 32'h300;
        @(negedge clk);
        chk("flush_idle_req", {31'd0, dm_req}, 32'd0);
        idle_inputs();

        // Flush while BUSY: request held until ack, no writeback
        @(negedge clk);
        valid = 1'b1; mem_rd = 1'b1; mem_size = 2'b10; addr = 32'h300; rd = 5'd8; wreg = 1'b1;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_req2", {31'd0, dm_req}, 32'd1);
        @(negedge clk);
        chk("flush_busy_req3", {31'd0, dm_req}, 32'd1);
        dm_ack = 1'b1; dm_rdata = 32'h12345678;
        @(negedge clk);
        chk("flush_busy_wbv", {31'd0, wb_valid}, 32'd0);
        chk("flush_busy_drop", {31'd0, dm_req}, 32'd0);
        idle_inputs();

        // Reset mid-BUSY drops everything immediately
        @(negedge clk);
        valid = 1'b1; mem_wr = 1'b1; mem_size = 2'b10; addr = 32'h400; wdata = 32'h11111111;
        @(negedge clk);
        chk("rstb_req_pre", {31'd0, dm_req}, 32'd1);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rstb_req", {31'd0, dm_req}, 32'd0);
        chk("rstb_we", {31'd0, dm_we}, 32'd0);
        chk("rstb_addr", dm_addr, 32'd0);
        chk("rstb_wdata", dm_wdata, 32'd0);
        chk("rstb_be", {28'd0, dm_be}, 32'd0);
        chk("rstb_wbdata", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef MISALIGN_EXC_EN
        @(negedge clk);
        valid = 1'b1; mem_rd = 1'b1; mem_size = 2'b10; addr = 32'h102; rd = 5'd5; wreg = 1'b1;
        @(negedge clk);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_req", {31'd0, dm_req}, 32'd0);
        chk("mis_wbv", {31'd0, wb_valid}, 32'd0);
        idle_inputs();
`else
        // Misaligned word load is forced to the aligned word
        mem_op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 5'd5, 1, 32'h11223344,
               32'h100, 4'b1111, 32'h0, 1'b1, 32'h11223344);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 5-stage RV32 core, directly downstream of the execute stage. It consumes the ALU result (effective address or writeback value) and the store operand forwarded by execute. It runs a single-outstanding request/acknowledge transaction to the data memory port, aligns store lanes, extracts and extends load data, and registers the writeback bundle for the WB stage. While a memory transaction is in flight it holds the pipeline through `stallreq_o`.

## Interface
- `ADDR_W`, 32, data-memory address width
- `DATA_W`, 32, data width; fixed at 32, other values unsupported
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `valid_i`  in  1  execute result valid this cycle
- `flush_i`  in  1  discard the current or in-flight op's writeback
- `mem_rd_i` / `mem_wr_i`  in  1 each  load / store op; never both high
- `mem_size_i`  in  2  00 byte, 01 half, 10 word; 11 treated as word
- `mem_unsigned_i`  in  1  zero-extend loads (LBU/LHU)
- `addr_i`  in  32  ALU result: effective address for memory ops, else writeback value
- `wdata_i`  in  32  store operand (rs2)
- `rd_i`  in  5  destination register
- `wreg_i`  in  1  writeback enable
- `dm_req_o`  out  1  memory request
- `dm_we_o`  out  1  write request
- `dm_addr_o`  out  ADDR_W  word-aligned address `{addr[31:2],2'b00}`
- `dm_wdata_o`  out  32  lane-replicated store data
- `dm_be_o`  out  4  byte enables, active-high
- `dm_ack_i`  in  1  request done; `dm_rdata_i` valid in the same cycle
- `dm_rdata_i`  in  32  read word
- `wb_valid_o`, `wb_wreg_o`  out  1 each  registered writeback valid / enable
- `wb_rd_o`  out  5  registered destination
- `wb_data_o`  out  32  registered writeback data
- `stallreq_o`  out  1  combinational hold request to the upstream stages
- `misalign_o`  out  1  registered misalignment exception; present only with `MISALIGN_EXC_EN`

## Operation
- **FSM states:** IDLE, BUSY.
- **Non-memory op in IDLE:** `addr_i` passes to `wb_data_o`, with `rd_i`/`wreg_i`, at the next edge. `wb_valid_o` = `valid_i & ~flush_i`.
- **Memory op in IDLE:**
  - Latch address, size, unsigned flag, rd, wreg and store data.
  - Enter BUSY. `dm_req_o` rises the following cycle.
- **BUSY:**
  - `dm_req_o`, `dm_we_o`, `dm_addr_o`, `dm_wdata_o` and `dm_be_o` stay stable until `dm_ack_i`.
  - On ack: return to IDLE. `wb_valid_o` = 1 for loads, 0 for stores. Load data is written to `wb_data_o`.
  - Inputs are ignored while BUSY.
- **Stall:** `stallreq_o` = `valid_i & (mem_rd_i|mem_wr_i) & ~(BUSY & dm_ack_i)`. It is low on the ack cycle so upstream advances together with the writeback edge.
- **Store lanes:**
  - Byte: `be` = 0001<<off, data = byte replicated ×4.
  - Half: `be` = 0011<<off, data = half replicated ×2.
  - Word: `be` = 1111.
  - off = `addr[1:0]`.
- **Load extract:** shift `dm_rdata_i` right by 8·off, then take byte or half. Sign-extend unless `mem_unsigned_i`. Word loads pass through unchanged.
- **Flush:**
  - In IDLE: suppresses `wb_valid_o` and starts no transaction.
  - In BUSY: the bus transaction still completes, but `wb_valid_o` stays 0 on ack (a sticky flag is cleared on return to IDLE).
- **Reset:**
  - State goes to IDLE.
  - All outputs are 0: `dm_req_o`, `dm_we_o`, `dm_addr_o`, `dm_wdata_o`, `dm_be_o`, `wb_*`, `misalign_o`.
  - Reset during BUSY drops `dm_req_o` immediately.

## Timing
- Cycle 0: op presented.
- Non-memory op: `wb_*` valid at cycle 1.
- Memory op:
  - `dm_req_o` high from cycle 1.
  - With ack in cycle N≥1, `wb_*` is valid at cycle N+1.
  - Minimum load-to-writeback latency: 2 cycles.
- `wb_valid_o` is a one-cycle pulse per completed op.
- `stallreq_o` is combinational from inputs and state, with no registered delay.
- An ack with `dm_req_o` low is ignored.

## Configuration
- Macro: `MISALIGN_EXC_EN`.
- **Defined:**
  - Misaligned ops (half with `addr[0]`=1, word with `addr[1:0]`≠0) issue no request and do not enter BUSY.
  - `misalign_o` pulses 1 at cycle 1; `wb_valid_o` = 0.
- **Undefined:**
  - No `misalign_o` port.
  - Offset is forced aligned: half uses `{addr[1],1'b0}`, word uses 0.
  - The access proceeds normally.

## Test plan
- **Word load/store:**
  - SW, addr 0x100, data 0xDEADBEEF, ack after 3 cycles → `dm_be_o`=1111, `stallreq_o` high 3 cycles, `wb_valid_o`=0.
  - LW to x5 → `wb_data_o`=0xDEADBEEF, `wb_rd_o`=5.
- **Sub-word store:** SB, addr 0x103, data 0x000000A5 → `dm_be_o`=1000, `dm_wdata_o`=0xA5A5A5A5. SH, addr 0x102, data 0x1234 → `dm_be_o`=1100, `dm_wdata_o`=0x12341234.
- **Load extension:** `dm_rdata_i`=0x80FF7F01:
  - LB off 2 → 0xFFFFFFFF; LBU off 2 → 0x000000FF.
  - LH off 2 → 0xFFFF80FF; LHU off 0 → 0x00007F01.
- **Back-to-back ops:** ALU op then immediate-ack load then ALU op → writebacks in cycles 1, 3, 4, no gaps or duplicates.
- **Flush:** flush while BUSY → `dm_req_o` held until ack, `wb_valid_o`=0. Reset asserted mid-BUSY → `dm_req_o`=0 immediately and all outputs zero.
- **Misalignment:** LW at 0x102:
  - With `MISALIGN_EXC_EN`: `misalign_o`=1, no `dm_req_o`.
  - Without: `dm_addr_o`=0x100 and full word returned.
